// File: rtl/mmc_cmd_framer_pkg.sv
// rtl/mmc_cmd_framer_pkg.sv - shared state encoding, frame lengths and long-response index list
package mmc_cmd_framer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_SHIFT     = 2'd1,
    ST_CHECK     = 2'd2,
    ST_SKIP_LONG = 2'd3
  } state_t;

  localparam int CMD_FRAME_BITS = 48;
  localparam int LONG_RESP_BITS = 136;
  localparam int CRC_COVER_BITS = 40;

  localparam int NUM_LONG_IDX = 3;
  localparam logic [5:0] LONG_IDX [NUM_LONG_IDX] = '{6'd2, 6'd9, 6'd10};

  function automatic logic is_long_idx(input logic [5:0] idx);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < NUM_LONG_IDX; i++) begin
      if (idx == LONG_IDX[i]) hit = 1'b1;
    end
    return hit;
  endfunction

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/mmc_crc7.sv
// rtl/mmc_crc7.sv - serial CRC7 (x^7+x^3+1, init 0); clear restarts from zero and may coincide with enable
module mmc_crc7 (
  input  logic       clk,
  input  logic       reset_i,
  input  logic       clear,
  input  logic       enable,
  input  logic       bit_in,
  output logic [6:0] crc
);

  logic [6:0] base;
  logic       fb;

  always_comb begin
    base = clear ? 7'd0 : crc;
    fb   = bit_in ^ base[6];
  end

  always_ff @(posedge clk or posedge reset_i) begin
    if (reset_i) begin
      crc <= 7'd0;
    end else if (enable) begin
      crc <= {base[5:3], base[2] ^ fb, base[1:0], fb};
    end else if (clear) begin
      crc <= 7'd0;
    end
  end

endmodule

// File: rtl/mmc_cmd_framer.sv
// rtl/mmc_cmd_framer.sv - frames 48-bit MMC CMD tokens from sampled mmc_clk/mmc_cmd, skipping 136-bit responses
// CRC7 checking is built only when MMC_CRC_CHECK_EN is defined; otherwise msg_crc_ok reads 1 after each frame.
module mmc_cmd_framer
  import mmc_cmd_framer_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic        clk,
  input  logic        reset_i,
  input  logic        mmc_clk,
  input  logic        mmc_cmd,
  output logic [47:0] msg_packet,
  output logic        msg_valid,
  output logic        msg_crc_ok,
  output logic        frame_err
);

  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  logic [SYNC_STAGES-1:0] clk_sync;
  logic [SYNC_STAGES-1:0] cmd_sync;
  logic                   clk_prev;
  logic                   clk_s;
  logic                   cmd_s;
  logic                   mmc_rise;

  state_t      state, state_next;
  logic [7:0]  bit_cnt;
  logic [46:0] shreg;
  logic [TW-1:0] to_cnt;
  logic        long_pending;
  logic        timeout_hit;
  logic        in_frame;
  logic        crc_ok_next;

  // Reset to 1 so a held-high mmc_clk never looks like a fresh rising edge.
  always_ff @(posedge clk or posedge reset_i) begin
    if (reset_i) begin
      clk_sync <= '1;
      cmd_sync <= '1;
      clk_prev <= 1'b1;
    end else begin
      clk_sync <= {clk_sync[SYNC_STAGES-2:0], mmc_clk};
      cmd_sync <= {cmd_sync[SYNC_STAGES-2:0], mmc_cmd};
      clk_prev <= clk_sync[SYNC_STAGES-1];
    end
  end

  assign clk_s    = clk_sync[SYNC_STAGES-1];
  assign cmd_s    = cmd_sync[SYNC_STAGES-1];
  assign mmc_rise = clk_s & ~clk_prev;

  assign in_frame    = (state == ST_SHIFT) || (state == ST_SKIP_LONG);
  assign timeout_hit = in_frame && !mmc_rise && (to_cnt == TW'(TIMEOUT_CYC - 1));

`ifdef MMC_CRC_CHECK_EN
  logic       crc_clear;
  logic       crc_en;
  logic [6:0] crc_val;

  always_comb begin
    crc_clear = (state == ST_IDLE);
    crc_en    = 1'b0;
    if (mmc_rise) begin
      if (state == ST_IDLE)
        crc_en = !cmd_s && !long_pending;
      else if (state == ST_SHIFT)
        crc_en = (bit_cnt < 8'(CRC_COVER_BITS));
    end
  end

  mmc_crc7 u_crc7 (
    .clk     (clk),
    .reset_i (reset_i),
    .clear   (crc_clear),
    .enable  (crc_en),
    .bit_in  (cmd_s),
    .crc     (crc_val)
  );

  // On the bit-48 edge the CRC field [7:1] sits in shreg[6:0].
  assign crc_ok_next = (crc_val == shreg[6:0]);
`else
  assign crc_ok_next = 1'b1;
`endif

  always_ff @(posedge clk or posedge reset_i) begin
    if (reset_i) state <= ST_IDLE;
    else         state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (mmc_rise && !cmd_s)
          state_next = long_pending ? ST_SKIP_LONG : ST_SHIFT;
      end
      ST_SHIFT: begin
        if (timeout_hit)
          state_next = ST_IDLE;
        else if (mmc_rise && bit_cnt == 8'(CMD_FRAME_BITS - 1))
          state_next = ST_CHECK;
      end
      ST_CHECK: state_next = ST_IDLE;
      ST_SKIP_LONG: begin
        if (timeout_hit)
          state_next = ST_IDLE;
        else if (mmc_rise && bit_cnt == 8'(LONG_RESP_BITS - 1))
          state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    msg_valid = 1'b0;
    frame_err = timeout_hit;
    if (state == ST_CHECK) begin
      msg_valid = msg_packet[0];
      frame_err = ~msg_packet[0];
    end
  end

  always_ff @(posedge clk or posedge reset_i) begin
    if (reset_i) begin
      bit_cnt      <= 8'd0;
      shreg        <= '0;
      to_cnt       <= '0;
      msg_packet   <= '0;
      msg_crc_ok   <= 1'b0;
      long_pending <= 1'b0;
    end else begin
      if (mmc_rise || !in_frame)
        to_cnt <= '0;
      else if (to_cnt != TW'(TIMEOUT_CYC))
        to_cnt <= to_cnt + TW'(1);

      case (state)
        ST_IDLE: begin
          if (mmc_rise && !cmd_s) begin
            bit_cnt <= 8'd1;
            shreg   <= '0;
          end
        end
        ST_SHIFT: begin
          if (mmc_rise) begin
            shreg   <= {shreg[45:0], cmd_s};
            bit_cnt <= sat_inc8(bit_cnt);
            if (bit_cnt == 8'(CMD_FRAME_BITS - 1)) begin
              msg_packet <= {shreg, cmd_s};
              msg_crc_ok <= crc_ok_next;
            end
          end
        end
        ST_CHECK: begin
          if (msg_packet[0] && msg_packet[46] && is_long_idx(msg_packet[45:40]))
            long_pending <= 1'b1;
        end
        ST_SKIP_LONG: begin
          if (mmc_rise) begin
            bit_cnt <= sat_inc8(bit_cnt);
            if (bit_cnt == 8'(LONG_RESP_BITS - 1))
              long_pending <= 1'b0;
          end
        end
        default: ;
      endcase

      if (timeout_hit)
        long_pending <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mmc_cmd_framer.sv
// tb/tb_mmc_cmd_framer.sv - directed self-checking bench for mmc_cmd_framer
module tb_mmc_cmd_framer;

  localparam int TO = 4096;
  localparam logic [47:0] CMD0     = 48'h400000000095;
  localparam logic [47:0] CMD0_BAD = 48'h400000000094;
  localparam logic [47:0] CMD17    = 48'h510000000055;
  localparam logic [47:0] CMD17_C  = 48'h510000000057;
  localparam logic [47:0] CMD2     = 48'h42000000004D;
  localparam logic [135:0] RESP136 = {8'h3F, 64'h0123456789ABCDEF, 64'hFEDCBA9876543211};

  logic        clk = 1'b0;
  logic        reset_i = 1'b1;
  logic        mmc_clk = 1'b1;
  logic        mmc_cmd = 1'b1;
  logic [47:0] msg_packet;
  logic        msg_valid;
  logic        msg_crc_ok;
  logic        frame_err;

  int errors = 0;
  int checks = 0;
  int pcyc = 0;
  int valid_cnt = 0;
  int err_cnt = 0;
  int valid_p = 0;
  int err_p = 0;
  int rise_p = 0;
  logic [47:0] last_pkt = '0;
  logic        last_ok = 1'b0;
  logic        exp_bad_ok;

  always #5 clk = ~clk;

  mmc_cmd_framer #(.SYNC_STAGES(2), .TIMEOUT_CYC(TO)) dut (
    .clk        (clk),
    .reset_i    (reset_i),
    .mmc_clk    (mmc_clk),
    .mmc_cmd    (mmc_cmd),
    .msg_packet (msg_packet),
    .msg_valid  (msg_valid),
    .msg_crc_ok (msg_crc_ok),
    .frame_err  (frame_err)
  );

  always @(posedge clk) pcyc <= pcyc + 1;

  always @(negedge clk) begin
    if (!reset_i) begin
      if (msg_valid) begin
        valid_cnt = valid_cnt + 1;
        valid_p   = pcyc;
        last_pkt  = msg_packet;
        last_ok   = msg_crc_ok;
      end
      if (frame_err) begin
        err_cnt = err_cnt + 1;
        err_p   = pcyc;
      end
    end
  end

  task automatic send_bit(input logic b, input int half);
    mmc_cmd = b;
    mmc_clk = 1'b0;
    repeat (half) @(negedge clk);
    mmc_clk = 1'b1;
    rise_p = pcyc;
    repeat (half) @(negedge clk);
  endtask

  task automatic send_frame(input logic [47:0] f, input int nbits, input int half);
    @(negedge clk);
    for (int i = 47; i >= 48 - nbits; i--) send_bit(f[i], half);
    mmc_cmd = 1'b1;
  endtask

  task automatic send_long(input logic [135:0] f, input int half);
    @(negedge clk);
    for (int i = 135; i >= 0; i--) send_bit(f[i], half);
    mmc_cmd = 1'b1;
  endtask

  task automatic settle;
    repeat (12) @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    #1;
    checks++; if (msg_packet !== 48'h0) begin errors++; $display("FAIL reset_pkt: got %h want %h", msg_packet, 48'h0); end
    checks++; if (msg_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", msg_valid); end
    checks++; if (msg_crc_ok !== 1'b0) begin errors++; $display("FAIL reset_crc_ok: got %b want 0", msg_crc_ok); end
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_frame_err: got %b want 0", frame_err); end
    @(negedge clk);
    reset_i = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_cmd0;
    int v0, e0;
    v0 = valid_cnt; e0 = err_cnt;
    send_frame(CMD0, 48, 2);
    settle();
    checks++; if (valid_cnt - v0 !== 1) begin errors++; $display("FAIL cmd0_valid_cnt: got %0d want 1", valid_cnt - v0); end
    checks++; if (last_pkt !== CMD0) begin errors++; $display("FAIL cmd0_pkt: got %h want %h", last_pkt, CMD0); end
    checks++; if (last_ok !== 1'b1) begin errors++; $display("FAIL cmd0_crc_ok: got %b want 1", last_ok); end
    checks++; if (err_cnt - e0 !== 0) begin errors++; $display("FAIL cmd0_err_cnt: got %0d want 0", err_cnt - e0); end
    checks++; if (msg_packet !== CMD0) begin errors++; $display("FAIL cmd0_hold: got %h want %h", msg_packet, CMD0); end
  endtask

  task automatic test_cmd17_latency;
    int v0;
    v0 = valid_cnt;
    send_frame(CMD17, 48, 4);
    settle();
    checks++; if (valid_cnt - v0 !== 1) begin errors++; $display("FAIL cmd17_valid_cnt: got %0d want 1", valid_cnt - v0); end
    checks++; if (valid_p - rise_p !== 3) begin errors++; $display("FAIL cmd17_latency: got %0d want 3", valid_p - rise_p); end
    checks++; if (last_pkt !== CMD17) begin errors++; $display("FAIL cmd17_pkt: got %h want %h", last_pkt, CMD17); end
    checks++; if (last_ok !== 1'b1) begin errors++; $display("FAIL cmd17_crc_ok: got %b want 1", last_ok); end
    v0 = valid_cnt;
    send_frame(CMD17_C, 48, 4);
    settle();
    checks++; if (valid_cnt - v0 !== 1) begin errors++; $display("FAIL cmd17c_valid_cnt: got %0d want 1", valid_cnt - v0); end
    checks++; if (last_pkt !== CMD17_C) begin errors++; $display("FAIL cmd17c_pkt: got %h want %h", last_pkt, CMD17_C); end
    checks++; if (last_ok !== exp_bad_ok) begin errors++; $display("FAIL cmd17c_crc_ok: got %b want %b", last_ok, exp_bad_ok); end
  endtask

  task automatic test_bad_end;
    int v0, e0;
    v0 = valid_cnt; e0 = err_cnt;
    send_frame(CMD0_BAD, 48, 2);
    settle();
    checks++; if (err_cnt - e0 !== 1) begin errors++; $display("FAIL badend_err_cnt: got %0d want 1", err_cnt - e0); end
    checks++; if (valid_cnt - v0 !== 0) begin errors++; $display("FAIL badend_valid_cnt: got %0d want 0", valid_cnt - v0); end
    checks++; if (msg_packet !== CMD0_BAD) begin errors++; $display("FAIL badend_pkt: got %h want %h", msg_packet, CMD0_BAD); end
  endtask

  task automatic test_long_skip;
    int v0, e0;
    v0 = valid_cnt; e0 = err_cnt;
    send_frame(CMD2, 48, 2);
    settle();
    checks++; if (last_pkt !== CMD2) begin errors++; $display("FAIL long_cmd2_pkt: got %h want %h", last_pkt, CMD2); end
    send_long(RESP136, 2);
    settle();
    checks++; if (msg_packet !== CMD2) begin errors++; $display("FAIL long_skip_hold: got %h want %h", msg_packet, CMD2); end
    send_frame(CMD0, 48, 2);
    settle();
    checks++; if (valid_cnt - v0 !== 2) begin errors++; $display("FAIL long_valid_cnt: got %0d want 2", valid_cnt - v0); end
    checks++; if (last_pkt !== CMD0) begin errors++; $display("FAIL long_cmd0_pkt: got %h want %h", last_pkt, CMD0); end
    checks++; if (err_cnt - e0 !== 0) begin errors++; $display("FAIL long_err_cnt: got %0d want 0", err_cnt - e0); end
  endtask

  task automatic test_timeout;
    int v0, e0;
    v0 = valid_cnt; e0 = err_cnt;
    send_frame(CMD0, 20, 2);
    repeat (5000) @(posedge clk);
    #1;
    checks++; if (err_cnt - e0 !== 1) begin errors++; $display("FAIL timeout_err_cnt: got %0d want 1", err_cnt - e0); end
    checks++; if (err_p - rise_p !== TO + 2) begin errors++; $display("FAIL timeout_time: got %0d want %0d", err_p - rise_p, TO + 2); end
    checks++; if (valid_cnt - v0 !== 0) begin errors++; $display("FAIL timeout_valid_cnt: got %0d want 0", valid_cnt - v0); end
    send_frame(CMD0, 48, 2);
    settle();
    checks++; if (valid_cnt - v0 !== 1) begin errors++; $display("FAIL timeout_next_valid: got %0d want 1", valid_cnt - v0); end
    checks++; if (last_pkt !== CMD0) begin errors++; $display("FAIL timeout_next_pkt: got %h want %h", last_pkt, CMD0); end
    checks++; if (err_cnt - e0 !== 1) begin errors++; $display("FAIL timeout_next_err: got %0d want 1", err_cnt - e0); end
  endtask

  task automatic test_reset_mid;
    int v0;
    v0 = valid_cnt;
    send_frame(CMD17, 30, 2);
    reset_i = 1'b1;
    #1;
    checks++; if (msg_packet !== 48'h0) begin errors++; $display("FAIL midrst_pkt: got %h want %h", msg_packet, 48'h0); end
    checks++; if (msg_valid !== 1'b0) begin errors++; $display("FAIL midrst_valid: got %b want 0", msg_valid); end
    checks++; if (msg_crc_ok !== 1'b0) begin errors++; $display("FAIL midrst_crc_ok: got %b want 0", msg_crc_ok); end
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL midrst_frame_err: got %b want 0", frame_err); end
    repeat (3) @(negedge clk);
    reset_i = 1'b0;
    repeat (4) @(negedge clk);
    send_frame(CMD0, 48, 2);
    settle();
    checks++; if (valid_cnt - v0 !== 1) begin errors++; $display("FAIL midrst_valid_cnt: got %0d want 1", valid_cnt - v0); end
    checks++; if (last_pkt !== CMD0) begin errors++; $display("FAIL midrst_pkt_after: got %h want %h", last_pkt, CMD0); end
    checks++; if (last_ok !== 1'b1) begin errors++; $display("FAIL midrst_crc_after: got %b want 1", last_ok); end
  endtask

  initial begin
`ifdef MMC_CRC_CHECK_EN
    exp_bad_ok = 1'b0;
`else
    exp_bad_ok = 1'b1;
`endif
    test_reset();
    test_cmd0();
    test_cmd17_latency();
    test_bad_end();
    test_long_skip();
    test_timeout();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
